// File: rtl/sap_program_loader.sv
// sap_program_loader: boot stage for the SAP-1 computer.
// Accepts a program image over a byte-stream valid/ready handshake, writes it
// into the 16x8 program RAM and holds the SAP core in reset until the image is
// complete plus a short settling delay.
// Optional feature: define SAP_LOADER_CHECKSUM_EN to expect one trailing
// checksum byte per image. A bad image parks the loader in an ERROR state.
module sap_program_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 16,
  parameter int RUN_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  output logic              We,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] wrData,
  output logic              cpuReset,
  output logic              loading,
  output logic              done,
  output logic              error
);

  // The hold counter must be able to hold RUN_HOLD itself.
  localparam int HOLD_W = (RUN_HOLD < 2) ? 1 : $clog2(RUN_HOLD + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RUN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3
`ifdef SAP_LOADER_CHECKSUM_EN
    ,
    S_ERROR = 3'd4
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wrData_q;
  logic                cpuReset_q;
  logic                loading_q;
  logic                done_q;
  logic                writeEn;
  logic                xfer;

`ifdef SAP_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                chkPhase_q, chkPhase_d;
  logic                error_q;
`endif

  // Ready is a pure decode of the current state so it drops the cycle after
  // the final transfer moves the FSM out of LOAD.
  assign byteReady = (state_q == S_LOAD);
  assign xfer      = byteValid && byteReady;

  // Next-state logic: load pointer, hold countdown and (optionally) checksum.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    holdCnt_d  = holdCnt_q;
    writeEn    = 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    chkPhase_d = chkPhase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
`ifdef SAP_LOADER_CHECKSUM_EN
          sum_d      = '0;
          chkPhase_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (xfer) begin
`ifdef SAP_LOADER_CHECKSUM_EN
          sum_d = sum_q + byteIn;
          if (chkPhase_q) begin
            chkPhase_d = 1'b0;
            if (sum_d == '0) begin
              state_d   = S_HOLD;
              holdCnt_d = HOLD_LOAD;
            end else begin
              state_d = S_ERROR;
            end
          end else begin
            writeEn = 1'b1;
            ptr_d   = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_ADDR) begin
              chkPhase_d = 1'b1;
            end
          end
`else
          writeEn = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_ADDR) begin
            state_d   = S_HOLD;
            holdCnt_d = HOLD_LOAD;
          end
`endif
        end
      end
      S_HOLD: begin
        if (holdCnt_q == HOLD_ONE) begin
          state_d = S_RUN;
        end else begin
          holdCnt_d = holdCnt_q - HOLD_ONE;
        end
      end
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
`ifdef SAP_LOADER_CHECKSUM_EN
          sum_d      = '0;
          chkPhase_d = 1'b0;
`endif
        end
      end
`ifdef SAP_LOADER_CHECKSUM_EN
      S_ERROR: begin
        if (start) begin
          state_d    = S_LOAD;
          ptr_d      = '0;
          sum_d      = '0;
          chkPhase_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer and hold counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      holdCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  // RAM write port: one-cycle strobe after each data transfer; address and
  // data keep their last values between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wrData_q <= '0;
    end else begin
      we_q <= writeEn;
      if (writeEn) begin
        addr_q   <= ptr_q;
        wrData_q <= byteIn;
      end
    end
  end

  // Status outputs registered from the next state so they match the state
  // register cycle for cycle without combinational glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpuReset_q <= 1'b1;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cpuReset_q <= (state_d != S_RUN);
      loading_q  <= (state_d == S_LOAD) || (state_d == S_HOLD);
      done_q     <= (state_d == S_RUN);
    end
  end

`ifdef SAP_LOADER_CHECKSUM_EN
  // Checksum accumulator, checksum-phase flag and registered error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q      <= '0;
      chkPhase_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      chkPhase_q <= chkPhase_d;
      error_q    <= (state_d == S_ERROR);
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign We       = we_q;
  assign Address  = addr_q;
  assign wrData   = wrData_q;
  assign cpuReset = cpuReset_q;
  assign loading  = loading_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sap_program_loader.sv
// tb_sap_program_loader: directed bench for sap_program_loader.
// Loads images continuously and with stalls, checks write timing, release
// timing, restart from RUN and asynchronous reset. With
// SAP_LOADER_CHECKSUM_EN defined every image gets a trailing checksum byte and
// good/bad checksum cases are exercised as well.
module tb_sap_program_loader;

`ifdef SAP_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byteIn = 8'h00;
  logic       byteValid = 1'b0;
  logic       byteReady;
  logic       We;
  logic [3:0] Address;
  logic [7:0] wrData;
  logic       cpuReset;
  logic       loading;
  logic       done;
  logic       error;

  int checkCount = 0;
  int failCount  = 0;

  logic [3:0] logAddr[$];
  logic [7:0] logData[$];
  bit         curIsChk = 1'b0;
  bit         expWe = 1'b0;

  sap_program_loader #(
    .ADDR_W   (4),
    .DATA_W   (8),
    .MEM_DEPTH(16),
    .RUN_HOLD (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .byteIn   (byteIn),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .We       (We),
    .Address  (Address),
    .wrData   (wrData),
    .cpuReset (cpuReset),
    .loading  (loading),
    .done     (done),
    .error    (error)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Write monitor: every byte offered (and not a checksum) must produce We in
  // exactly the following cycle; writes are logged for content checks.
  always @(negedge clk) begin
    checkOutput("weTiming", 32'(We), reset ? 32'd0 : 32'(expWe));
    if (We) begin
      logAddr.push_back(Address);
      logData.push_back(wrData);
    end
    expWe = byteValid && !curIsChk && !reset;
  end

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives count data bytes base+step*i; optionally appends a checksum byte
  // (corrupted by +1 when badChk) in the checksum build. Returns #1 after the
  // final transfer edge with byteValid low.
  task automatic applyStimulus(input logic [7:0] base, input logic [7:0] step,
                               input bit gap, input int count,
                               input bit sendChk, input bit badChk);
    int  sum;
    bit  withChk;
    sum = 0;
    withChk = sendChk && CHK;
    for (int i = 0; i < count; i++) begin
      byteIn    = 8'(base + step * i);
      sum       = sum + int'(byteIn);
      byteValid = 1'b1;
      @(posedge clk); #1;
      byteValid = 1'b0;
      if (gap && (i != count - 1 || withChk)) begin
        @(posedge clk); #1;
      end
    end
    if (withChk) begin
      byteIn    = 8'(256 - (sum % 256)) + (badChk ? 8'd1 : 8'd0);
      curIsChk  = 1'b1;
      byteValid = 1'b1;
      @(posedge clk); #1;
      byteValid = 1'b0;
      curIsChk  = 1'b0;
    end
  endtask

  // Release sequence after the last transfer: two HOLD cycles, then RUN.
  task automatic checkRelease(input string tag);
    checkOutput({tag, ".readyDrop"}, 32'(byteReady), 32'd0);
    checkOutput({tag, ".lastWe"}, 32'(We), CHK ? 32'd0 : 32'd1);
    checkOutput({tag, ".hold1CpuRst"}, 32'(cpuReset), 32'd1);
    checkOutput({tag, ".hold1Loading"}, 32'(loading), 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, ".hold2CpuRst"}, 32'(cpuReset), 32'd1);
    checkOutput({tag, ".hold2Done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, ".runCpuRst"}, 32'(cpuReset), 32'd0);
    checkOutput({tag, ".runDone"}, 32'(done), 32'd1);
    checkOutput({tag, ".runLoading"}, 32'(loading), 32'd0);
    checkOutput({tag, ".runError"}, 32'(error), 32'd0);
  endtask

  // Compares the logged writes against the expected 16-entry image.
  task automatic checkLog(input string tag, input logic [7:0] base,
                          input logic [7:0] step);
    checkOutput({tag, ".writes"}, 32'(logAddr.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < logAddr.size()) begin
        checkOutput($sformatf("%s.addr[%0d]", tag, i), 32'(logAddr[i]), 32'(i));
        checkOutput($sformatf("%s.data[%0d]", tag, i), 32'(logData[i]),
                    32'(8'(base + step * i)));
      end
    end
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    $display("[TB] starting sap_program_loader bench (checksum=%0d)", CHK);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst.ready", 32'(byteReady), 32'd0);
    checkOutput("rst.we", 32'(We), 32'd0);
    checkOutput("rst.addr", 32'(Address), 32'd0);
    checkOutput("rst.data", 32'(wrData), 32'd0);
    checkOutput("rst.cpuRst", 32'(cpuReset), 32'd1);
    checkOutput("rst.loading", 32'(loading), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.error", 32'(error), 32'd0);
    reset = 1'b0;

    // Idle without start: nothing moves.
    @(posedge clk); #1;
    checkOutput("idle.ready", 32'(byteReady), 32'd0);
    checkOutput("idle.cpuRst", 32'(cpuReset), 32'd1);

    // Continuous load 0x10..0x1F.
    clearLog();
    pulseStart();
    checkOutput("load1.ready", 32'(byteReady), 32'd1);
    checkOutput("load1.loading", 32'(loading), 32'd1);
    applyStimulus(8'h10, 8'h01, 1'b0, 16, 1'b1, 1'b0);
    checkRelease("load1");
    checkLog("load1", 8'h10, 8'h01);

    // Restart from RUN, then a stalled load 0x20..0x2F.
    @(posedge clk); #1;
    clearLog();
    pulseStart();
    checkOutput("restart.cpuRst", 32'(cpuReset), 32'd1);
    checkOutput("restart.done", 32'(done), 32'd0);
    checkOutput("restart.ready", 32'(byteReady), 32'd1);
    applyStimulus(8'h20, 8'h01, 1'b1, 16, 1'b1, 1'b0);
    checkRelease("gapLoad");
    checkLog("gapLoad", 8'h20, 8'h01);

    // Asynchronous reset from RUN, mid-cycle.
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRun.cpuRst", 32'(cpuReset), 32'd1);
    checkOutput("asyncRun.done", 32'(done), 32'd0);
    checkOutput("asyncRun.addr", 32'(Address), 32'd0);
    checkOutput("asyncRun.data", 32'(wrData), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset right after the 7th accept, while its write strobe is high.
    clearLog();
    pulseStart();
    applyStimulus(8'h50, 8'h01, 1'b0, 7, 1'b0, 1'b0);
    checkOutput("midLoad.we7", 32'(We), 32'd1);
    checkOutput("midLoad.addr7", 32'(Address), 32'd6);
    #1 reset = 1'b1;
    #1;
    checkOutput("midLoad.we", 32'(We), 32'd0);
    checkOutput("midLoad.addr", 32'(Address), 32'd0);
    checkOutput("midLoad.ready", 32'(byteReady), 32'd0);
    checkOutput("midLoad.cpuRst", 32'(cpuReset), 32'd1);
    checkOutput("midLoad.loading", 32'(loading), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("midLoad.idleReady", 32'(byteReady), 32'd0);
    clearLog();
    pulseStart();
    applyStimulus(8'h60, 8'h03, 1'b0, 16, 1'b1, 1'b0);
    checkRelease("reload");
    checkLog("reload", 8'h60, 8'h03);

`ifdef SAP_LOADER_CHECKSUM_EN
    // Sixteen 0x01 bytes followed by 0xF0: good image.
    @(posedge clk); #1;
    clearLog();
    pulseStart();
    applyStimulus(8'h01, 8'h00, 1'b0, 16, 1'b1, 1'b0);
    checkOutput("chkGood.byte", 32'(byteIn), 32'hF0);
    checkRelease("chkGood");
    checkLog("chkGood", 8'h01, 8'h00);

    // Same bytes followed by 0xF1: ERROR.
    clearLog();
    pulseStart();
    applyStimulus(8'h01, 8'h00, 1'b0, 16, 1'b1, 1'b1);
    checkOutput("chkBad.byte", 32'(byteIn), 32'hF1);
    checkOutput("chkBad.error", 32'(error), 32'd1);
    checkOutput("chkBad.cpuRst", 32'(cpuReset), 32'd1);
    checkOutput("chkBad.done", 32'(done), 32'd0);
    checkOutput("chkBad.ready", 32'(byteReady), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("chkBad.errorHeld", 32'(error), 32'd1);
    checkOutput("chkBad.cpuRstHeld", 32'(cpuReset), 32'd1);
    checkLog("chkBad", 8'h01, 8'h00);

    // Leaving ERROR via start clears error and the running sum.
    clearLog();
    pulseStart();
    checkOutput("chkRecover.error", 32'(error), 32'd0);
    checkOutput("chkRecover.loading", 32'(loading), 32'd1);
    applyStimulus(8'h30, 8'h01, 1'b0, 16, 1'b1, 1'b0);
    checkRelease("chkRecover");
    checkLog("chkRecover", 8'h30, 8'h01);
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
